// File: rtl/apb_master_if.sv
// Command/response stream plus APB3 bus seen by the apb_master requester.
// The master modport is the requester's view; slave is the view of whoever drives commands and responds.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: converts a valid/ready command stream into SETUP/ACCESS transfers,
// returning one response pulse per command, with an optional timeout on a stuck pready.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          arst,
  apb_master_if.master  bus
);
  localparam int CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  psel_reg;
  logic                  penable_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;

  logic                  cmd_ready_int;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  timeout_hit;

  // Ready in the completing ACCESS cycle lets a new command start without an IDLE gap.
  assign cmd_ready_int = (state_reg == IDLE) || ((state_reg == ACCESS) && bus.pready);
  assign accept        = bus.cmd_valid && cmd_ready_int;
  assign cnt_inc       = cnt_reg + CNT_WIDTH'(1);
  assign timeout_hit   = (TIMEOUT != 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      paddr_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= pwrite_reg ? '0 : bus.prdata;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_inc;
            if (timeout_hit) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              psel_reg      <= 1'b0;
              penable_reg   <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        default: begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
      // A new command overrides the drop to IDLE, keeping psel high across back-to-back transfers.
      if (accept) begin
        paddr_reg   <= bus.cmd_addr;
        pwrite_reg  <= bus.cmd_write;
        pwdata_reg  <= bus.cmd_wdata;
        psel_reg    <= 1'b1;
        penable_reg <= 1'b0;
        cnt_reg     <= '0;
        state_reg   <= SETUP;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.psel      = psel_reg;
  assign bus.penable   = penable_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.pwdata    = pwdata_reg;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB memory responder with configurable wait states,
// reference memory model and per-scenario checking tasks.
module tb_apb_master;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Responder: wait_cfg low cycles of pready per ACCESS, -1 means pready never rises.
  logic [DW-1:0] slv_mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  int wait_cfg = 0;
  int acc_cnt = 0;

  always @(negedge clk) begin
    if (bus.psel && bus.penable && wait_cfg >= 0 && acc_cnt >= wait_cfg) begin
      bus.pready <= 1'b1;
      bus.prdata <= slv_mem[bus.paddr];
    end else if (bus.psel && bus.penable) begin
      bus.pready <= 1'b0;
      bus.prdata <= $urandom;
    end else begin
      bus.pready <= 1'($urandom);
      bus.prdata <= $urandom;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.psel && bus.penable) begin
      if (bus.pready) begin
        acc_cnt <= 0;
        if (bus.pwrite) slv_mem[bus.paddr] <= bus.pwdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // Monitor: bus history per cycle and the response stream.
  logic          psel_h  [0:1023];
  logic          pen_h   [0:1023];
  logic [AW-1:0] paddr_h [0:1023];
  logic [DW-1:0] pwdata_h[0:1023];
  logic [DW-1:0] rsp_data_q[$];
  logic          rsp_err_q[$];
  int            rsp_cyc_q[$];

  always @(posedge clk) begin
    #1;
    psel_h[cyc % 1024]   = bus.psel;
    pen_h[cyc % 1024]    = bus.penable;
    paddr_h[cyc % 1024]  = bus.paddr;
    pwdata_h[cyc % 1024] = bus.pwdata;
    if (bus.rsp_valid === 1'b1) begin
      rsp_data_q.push_back(bus.rsp_rdata);
      rsp_err_q.push_back(bus.rsp_err);
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_rsp();
    rsp_data_q.delete();
    rsp_err_q.delete();
    rsp_cyc_q.delete();
  endtask

  // Drive one command; acc_cyc is the cycle of the accepting edge, -1 if never accepted.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int acc_cyc);
    acc_cyc = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 64; i++) begin
      #4;
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 200 && rsp_data_q.size() < n; i++) @(posedge clk);
    #2;
    ok = (rsp_data_q.size() >= n);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h expected all 0",
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
    end
    @(negedge clk);
    arst = 1'b0;
    $display("txn reset released at cycle %0d", cyc);
  endtask

  task automatic test_write_read();
    int a0, a1;
    bit ok;
    wait_cfg = 0;
    clear_rsp();
    send(1'b1, 8'h05, 32'hDEADBEEF, a0);
    ref_mem[5] = 32'hDEADBEEF;
    send(1'b0, 8'h05, 32'h0, a1);
    wait_rsp(2, ok);
    checks++;
    if (!ok || a0 < 0 || a1 != a0 + 2) begin
      failures++;
      $display("FAIL wr_rd_accept: rsps=%0d a0=%0d a1=%0d expected 2 rsps a1=a0+2",
               rsp_data_q.size(), a0, a1);
    end else begin
      checks++;
      if (psel_h[a0 % 1024] !== 1'b1 || pen_h[a0 % 1024] !== 1'b0 ||
          psel_h[(a0 + 1) % 1024] !== 1'b1 || pen_h[(a0 + 1) % 1024] !== 1'b1) begin
        failures++;
        $display("FAIL wr_rd_phases: setup=%b%b access=%b%b expected 10 11",
                 psel_h[a0 % 1024], pen_h[a0 % 1024],
                 psel_h[(a0 + 1) % 1024], pen_h[(a0 + 1) % 1024]);
      end
      checks++;
      if (rsp_data_q[0] !== 32'h0 || rsp_err_q[0] !== 1'b0 || rsp_cyc_q[0] != a0 + 2) begin
        failures++;
        $display("FAIL wr_rsp: data=%h err=%b cyc=%0d expected 0 0 %0d",
                 rsp_data_q[0], rsp_err_q[0], rsp_cyc_q[0], a0 + 2);
      end
      checks++;
      if (rsp_data_q[1] !== 32'hDEADBEEF || rsp_err_q[1] !== 1'b0 || rsp_cyc_q[1] != a1 + 2) begin
        failures++;
        $display("FAIL rd_rsp: data=%h err=%b cyc=%0d expected deadbeef 0 %0d",
                 rsp_data_q[1], rsp_err_q[1], rsp_cyc_q[1], a1 + 2);
      end
      $display("txn write 05<-deadbeef rsp=%h err=%b", rsp_data_q[0], rsp_err_q[0]);
      $display("txn read 05 rsp=%h err=%b", rsp_data_q[1], rsp_err_q[1]);
    end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    logic [DW-1:0] d;
    bit ok;
    wait_cfg = 0;
    clear_rsp();
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      send(1'b1, AW'(k), d, acc[k]);
      ref_mem[k] = d;
    end
    wait_rsp(4, ok);
    checks++;
    if (!ok || acc[0] < 0) begin
      failures++;
      $display("FAIL b2b_count: rsps=%0d acc0=%0d expected 4 rsps", rsp_data_q.size(), acc[0]);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (acc[k] != acc[0] + 2 * k) begin
          failures++;
          $display("FAIL b2b_accept%0d: cycle %0d expected %0d", k, acc[k], acc[0] + 2 * k);
        end
      end
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (psel_h[(acc[0] + j) % 1024] !== 1'b1 || pen_h[(acc[0] + j) % 1024] !== 1'(j % 2)) begin
          failures++;
          $display("FAIL b2b_bus%0d: psel=%b penable=%b expected 1 %0d", j,
                   psel_h[(acc[0] + j) % 1024], pen_h[(acc[0] + j) % 1024], j % 2);
        end
      end
      checks++;
      if (psel_h[(acc[0] + 8) % 1024] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle: psel=%b expected 0", psel_h[(acc[0] + 8) % 1024]);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rsp_cyc_q[k] != acc[0] + 2 + 2 * k || rsp_err_q[k] !== 1'b0 || rsp_data_q[k] !== '0) begin
          failures++;
          $display("FAIL b2b_rsp%0d: cyc=%0d err=%b data=%h expected %0d 0 0", k,
                   rsp_cyc_q[k], rsp_err_q[k], rsp_data_q[k], acc[0] + 2 + 2 * k);
        end
        $display("txn b2b write %0d<-%h rsp_cycle=%0d", k, ref_mem[k], rsp_cyc_q[k]);
      end
    end
  endtask

  task automatic test_wait_states();
    int acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    wait_cfg = 3;
    clear_rsp();
    a = AW'($urandom_range(16, 255));
    d = $urandom;
    send(1'b1, a, d, acc);
    ref_mem[a] = d;
    wait_rsp(1, ok);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (!ok || rsp_data_q.size() != 1 || rsp_cyc_q[0] != acc + 5 || rsp_err_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL wait_rsp: rsps=%0d cyc=%0d err=%b expected 1 rsp at %0d err 0",
               rsp_data_q.size(), rsp_cyc_q[0], rsp_err_q[0], acc + 5);
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (psel_h[(acc + j) % 1024] !== 1'b1 || pen_h[(acc + j) % 1024] !== 1'b1 ||
          paddr_h[(acc + j) % 1024] !== a || pwdata_h[(acc + j) % 1024] !== d) begin
        failures++;
        $display("FAIL wait_stable%0d: psel=%b pen=%b paddr=%h pwdata=%h expected 1 1 %h %h", j,
                 psel_h[(acc + j) % 1024], pen_h[(acc + j) % 1024],
                 paddr_h[(acc + j) % 1024], pwdata_h[(acc + j) % 1024], a, d);
      end
    end
    $display("txn wait-state write %h<-%h rsps=%0d", a, d, rsp_data_q.size());
  endtask

  task automatic test_timeout();
    int acc;
    bit ok;
    wait_cfg = -1;
    clear_rsp();
    send(1'b0, 8'h05, $urandom, acc);
    wait_rsp(1, ok);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (!ok || rsp_data_q.size() != 1 || rsp_cyc_q[0] != acc + 1 + TMO ||
        rsp_err_q[0] !== 1'b1 || rsp_data_q[0] !== '0) begin
      failures++;
      $display("FAIL timeout_rsp: rsps=%0d cyc=%0d err=%b data=%h expected 1 rsp at %0d err 1 data 0",
               rsp_data_q.size(), rsp_cyc_q[0], rsp_err_q[0], rsp_data_q[0], acc + 1 + TMO);
    end
    checks++;
    if (pen_h[(acc + TMO) % 1024] !== 1'b1 || psel_h[(acc + TMO + 1) % 1024] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_bus: last_access_pen=%b next_psel=%b expected 1 0",
               pen_h[(acc + TMO) % 1024], psel_h[(acc + TMO + 1) % 1024]);
    end
    $display("txn timeout read 05 err=%b", rsp_err_q[0]);
    wait_cfg = 0;
    clear_rsp();
    send(1'b0, 8'h05, 32'h0, acc);
    wait_rsp(1, ok);
    checks++;
    if (!ok || rsp_data_q[0] !== ref_mem[5] || rsp_err_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout: data=%h err=%b expected %h 0", rsp_data_q[0], rsp_err_q[0], ref_mem[5]);
    end
    $display("txn read 05 after timeout rsp=%h", rsp_data_q[0]);
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    wait_cfg = -1;
    clear_rsp();
    send(1'b0, 8'h05, 32'h0, acc);
    @(posedge clk);
    #3;
    arst = 1'b1;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid: psel/penable/rsp_valid=%b expected 000",
               {bus.psel, bus.penable, bus.rsp_valid});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (rsp_data_q.size() != 0) begin
      failures++;
      $display("FAIL reset_no_rsp: rsps=%0d expected 0", rsp_data_q.size());
    end
    wait_cfg = 1;
    send(1'b0, 8'h05, 32'h0, acc);
    wait_rsp(1, ok);
    checks++;
    if (!ok || rsp_data_q[0] !== ref_mem[5] || rsp_err_q[0] !== 1'b0 || rsp_cyc_q[0] != acc + 3) begin
      failures++;
      $display("FAIL reset_reread: data=%h err=%b cyc=%0d expected %h 0 %0d",
               rsp_data_q[0], rsp_err_q[0], rsp_cyc_q[0], ref_mem[5], acc + 3);
    end
    $display("txn read 05 after reset rsp=%h", rsp_data_q[0]);
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int acc;
    int lost;
    bit ok;
    wait_cfg = 1;
    clear_rsp();
    lost = 0;
    for (int i = 0; i < 256; i++) begin
      w = 1'($urandom);
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      send(w, a, d, acc);
      if (acc < 0) begin
        lost++;
      end else if (w) begin
        ref_mem[a] = d;
        exp_q.push_back('0);
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    wait_rsp(exp_q.size(), ok);
    checks++;
    if (!ok || lost != 0 || rsp_data_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: rsps=%0d lost=%0d expected %0d rsps 0 lost",
               rsp_data_q.size(), lost, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rsp_data_q[i] !== exp_q[i] || rsp_err_q[i] !== 1'b0) begin
          failures++;
          $display("FAIL rand_rsp%0d: data=%h err=%b expected %h 0", i, rsp_data_q[i], rsp_err_q[i], exp_q[i]);
        end
        $display("txn rand %0d rsp=%h err=%b", i, rsp_data_q[i], rsp_err_q[i]);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
